// File: rtl/dodgypla_input_sequencer.sv
// Input sequencer for the PLA decode core: synchronises and debounces the pins,
// applies stable vectors to the core, and captures core outputs after a decode delay.
module dodgypla_input_sequencer #(
  parameter int FILTER_CYCLES = 3,
  parameter int DECODE_CYCLES = 2,
  parameter int MAX_WAIT      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pla_pins,
  input  logic        cfg_bypass,
  input  logic        glitch_clr,
  output logic [15:0] core_in,
  input  logic [7:0]  core_out,
  output logic [7:0]  f_out,
  output logic        upd_pulse,
  output logic        timeout_pulse,
  output logic [7:0]  glitch_cnt
);

  localparam int SW = $clog2(FILTER_CYCLES) + 1;
  localparam int WW = $clog2(MAX_WAIT) + 1;
  localparam int DW = $clog2(DECODE_CYCLES) + 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(FILTER_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECODE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, EVAL} state_t;

  state_t        state;
  logic [15:0]   pins_p0;
  logic [15:0]   pins_p1;
  logic [15:0]   cand;
  logic [SW-1:0] stab;
  logic [WW-1:0] wait_cnt;
  logic [DW-1:0] dec_cnt;

  logic [15:0] sync_in;
  logic        cand_diff;
  logic        stab_done;
  logic        wait_done;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign sync_in   = pins_p1;
  assign cand_diff = (sync_in != cand);
  assign stab_done = !cand_diff && (stab == STAB_LAST);
  assign wait_done = (wait_cnt == WAIT_LAST);

  // Stage p0/p1: two-flop synchroniser on the raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pins_p0 <= '0;
      pins_p1 <= '0;
    end else begin
      pins_p0 <= pla_pins;
      pins_p1 <= pins_p0;
    end
  end

  // Sequencing FSM with registered core inputs, pin drivers and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cand          <= '0;
      stab          <= '0;
      wait_cnt      <= '0;
      dec_cnt       <= '0;
      core_in       <= '0;
      f_out         <= 8'hFF;
      upd_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      glitch_cnt    <= '0;
    end else begin
      upd_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      if (cfg_bypass) begin
        core_in <= sync_in;
        f_out   <= core_out;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (sync_in != core_in) begin
              cand     <= sync_in;
              stab     <= '0;
              wait_cnt <= '0;
              state    <= SETTLE;
            end
          end
          SETTLE: begin
            wait_cnt <= wait_cnt + 1'b1;
            if (cand_diff) begin
              cand <= sync_in;
              stab <= '0;
            end else if (stab_done) begin
              stab <= '0;
              if (cand == core_in) begin
                state <= IDLE;
              end else begin
                core_in <= cand;
                dec_cnt <= '0;
                state   <= EVAL;
              end
            end else begin
              stab <= stab + 1'b1;
            end
            // A stable exit in the same cycle beats the forced apply
            if (wait_done && !stab_done) begin
              core_in       <= sync_in;
              timeout_pulse <= 1'b1;
              dec_cnt       <= '0;
              state         <= EVAL;
            end
          end
          EVAL: begin
            if (dec_cnt == DEC_LAST) begin
              f_out     <= core_out;
              upd_pulse <= 1'b1;
              state     <= IDLE;
            end else begin
              dec_cnt <= dec_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (glitch_clr)
        glitch_cnt <= '0;
      else if (!cfg_bypass && state == SETTLE && cand_diff)
        glitch_cnt <= sat_inc8(glitch_cnt);
    end
  end

endmodule

// File: tb/tb_dodgypla_input_sequencer.sv
// Scoreboard bench for dodgypla_input_sequencer: timestamp-based reference model
// predicts pulses and outputs; a negedge monitor compares against the DUT.
module tb_dodgypla_input_sequencer;

  localparam int FILTER = 3;
  localparam int DECODE = 2;
  localparam int MAXW   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pla_pins;
  logic        cfg_bypass;
  logic        glitch_clr;
  logic [15:0] core_in;
  logic [7:0]  core_out;
  logic [7:0]  f_out;
  logic        upd_pulse;
  logic        timeout_pulse;
  logic [7:0]  glitch_cnt;

  int errors = 0;
  int checks = 0;
  int upd_seen = 0;
  int to_seen = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] pla_f(input logic [15:0] x);
    return x[7:0] ^ {x[12:8], x[15:13]} ^ 8'hA5;
  endfunction

  assign core_out = pla_f(core_in);

  dodgypla_input_sequencer #(
    .FILTER_CYCLES(FILTER),
    .DECODE_CYCLES(DECODE),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pla_pins(pla_pins),
    .cfg_bypass(cfg_bypass),
    .glitch_clr(glitch_clr),
    .core_in(core_in),
    .core_out(core_out),
    .f_out(f_out),
    .upd_pulse(upd_pulse),
    .timeout_pulse(timeout_pulse),
    .glitch_cnt(glitch_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          cyc;
    bit          is_to;
    logic [15:0] ci;
    logic [7:0]  fo;
  } ev_t;
  ev_t sb[$];

  // Reference model: pins become visible two edges later; settling is tracked by
  // the edge at which the candidate was last changed and the edge SETTLE began.
  int          cyc = 0;
  int          m_mode;
  int          t_entry, t_stable, t_eval;
  logic [15:0] m_h0, m_h1, m_cand, m_core_in;
  logic [7:0]  m_f_out, m_glitch;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] sync_now;
    bit          exited;
    if (!rst_n) begin
      m_h0 = '0; m_h1 = '0; m_cand = '0; m_core_in = '0;
      m_f_out = 8'hFF; m_glitch = '0; m_mode = 0;
      t_entry = 0; t_stable = 0; t_eval = 0;
    end else begin
      cyc++;
      sync_now = m_h0;
      m_h0 = m_h1;
      m_h1 = pla_pins;
      if (cfg_bypass) begin
        m_f_out = pla_f(m_core_in);
        m_core_in = sync_now;
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (sync_now != m_core_in) begin
          m_cand = sync_now; t_entry = cyc; t_stable = cyc; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        exited = 0;
        if (sync_now != m_cand) begin
          m_cand = sync_now; t_stable = cyc;
          if (m_glitch != 8'd255) m_glitch = m_glitch + 8'd1;
        end else if (cyc - t_stable == FILTER) begin
          exited = 1;
          if (m_cand == m_core_in) m_mode = 0;
          else begin
            m_core_in = m_cand; m_mode = 2; t_eval = cyc + DECODE;
          end
        end
        if (!exited && cyc - t_entry == MAXW) begin
          m_core_in = sync_now; m_mode = 2; t_eval = cyc + DECODE;
          sb.push_back('{cyc: cyc, is_to: 1'b1, ci: m_core_in, fo: m_f_out});
        end
      end else begin
        if (cyc == t_eval) begin
          m_f_out = pla_f(m_core_in);
          m_mode = 0;
          sb.push_back('{cyc: cyc, is_to: 1'b0, ci: m_core_in, fo: m_f_out});
        end
      end
      if (glitch_clr) m_glitch = '0;
    end
  end

  // Monitor: compares outputs every cycle and pops the scoreboard on each pulse
  always @(negedge clk) begin
    ev_t e;
    chk("f_out", {24'd0, f_out}, {24'd0, m_f_out});
    chk("core_in", {16'd0, core_in}, {16'd0, m_core_in});
    chk("glitch_cnt", {24'd0, glitch_cnt}, {24'd0, m_glitch});
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missed_pulse_cyc", 32'(cyc), 32'(sb[0].cyc));
      void'(sb.pop_front());
    end
    if (upd_pulse) upd_seen++;
    if (timeout_pulse) to_seen++;
    if (upd_pulse || timeout_pulse) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        chk("unexpected_pulse", {30'd0, upd_pulse, timeout_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, upd_pulse, timeout_pulse}, {30'd0, !e.is_to, e.is_to});
        chk("pulse_core_in", {16'd0, core_in}, {16'd0, e.ci});
        chk("pulse_f_out", {24'd0, f_out}, {24'd0, e.fo});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int u0, t0;
    rst_n = 1'b0; pla_pins = '0; cfg_bypass = 1'b0; glitch_clr = 1'b0;
    tick(3);
    chk("reset_f_out", {24'd0, f_out}, 32'hFF);
    rst_n = 1'b1;
    tick(5);
    chk("idle_f_out_ff", {24'd0, f_out}, 32'hFF);

    // Single clean change
    u0 = upd_seen; t0 = to_seen;
    pla_pins = 16'h2CE6;
    tick(12);
    chk("t1_upd_count", 32'(upd_seen - u0), 32'd1);
    chk("t1_to_count", 32'(to_seen - t0), 32'd0);
    chk("t1_f_out", {24'd0, f_out}, {24'd0, pla_f(16'h2CE6)});
    chk("t1_glitch", {24'd0, glitch_cnt}, 32'd0);

    // Slow toggling that eventually settles
    pla_pins = 16'h0000;
    tick(12);
    u0 = upd_seen;
    for (int i = 0; i < 5; i++) begin
      pla_pins = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      tick(2);
    end
    pla_pins = 16'h0001;
    tick(15);
    chk("t2_upd_count", 32'(upd_seen - u0), 32'd1);
    chk("t2_glitch_nz", {31'd0, glitch_cnt != 8'd0}, 32'd1);
    chk("t2_core_in", {16'd0, core_in}, 32'h0001);

    // Continuous toggling forces timeouts
    t0 = to_seen;
    for (int i = 0; i < 40; i++) begin
      pla_pins = (i % 2 == 0) ? 16'h0000 : 16'h0001;
      tick(1);
    end
    pla_pins = 16'h0000;
    tick(25);
    chk("t3_to_count_ge2", {31'd0, (to_seen - t0) >= 2}, 32'd1);

    // One-clock blip returns to IDLE without an apply
    glitch_clr = 1'b1; tick(1); glitch_clr = 1'b0;
    u0 = upd_seen;
    pla_pins = 16'h0040; tick(1);
    pla_pins = 16'h0000; tick(15);
    chk("t4_upd_count", 32'(upd_seen - u0), 32'd0);
    chk("t4_glitch", {24'd0, glitch_cnt}, 32'd1);

    // Bypass, including an abort from SETTLE
    cfg_bypass = 1'b1;
    pla_pins = 16'hFFFF; tick(4);
    chk("t5_byp_core_in", {16'd0, core_in}, 32'hFFFF);
    chk("t5_byp_f_out", {24'd0, f_out}, {24'd0, pla_f(16'hFFFF)});
    pla_pins = 16'h0000; tick(4);
    cfg_bypass = 1'b0;
    u0 = upd_seen; t0 = to_seen;
    tick(5);
    pla_pins = 16'h1234; tick(3);
    cfg_bypass = 1'b1; tick(3);
    cfg_bypass = 1'b0; tick(10);
    chk("t5_no_pulses", 32'((upd_seen - u0) + (to_seen - t0)), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      pla_pins   = 16'($urandom);
      cfg_bypass = ($urandom_range(0, 9) == 0);
      glitch_clr = ($urandom_range(0, 7) == 0);
      tick($urandom_range(1, 7));
    end
    cfg_bypass = 1'b0; glitch_clr = 1'b0;
    tick(25);

    // Saturation of the glitch counter, then clear
    for (int i = 0; i < 400; i++) begin
      pla_pins = (i % 2 == 0) ? 16'h8000 : 16'h0000;
      tick(1);
    end
    pla_pins = 16'h0000;
    tick(25);
    chk("t6_glitch_sat", {24'd0, glitch_cnt}, 32'd255);
    glitch_clr = 1'b1; tick(1); glitch_clr = 1'b0;
    chk("t6_glitch_clr", {24'd0, glitch_cnt}, 32'd0);

    // Asynchronous reset while in EVAL
    pla_pins = 16'hBEEF;
    for (int i = 0; i < 20 && m_mode != 2; i++) tick(1);
    chk("t6_eval_reached", 32'(m_mode), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_async_f_out", {24'd0, f_out}, 32'hFF);
    chk("t6_async_core_in", {16'd0, core_in}, 32'd0);
    chk("t6_async_upd", {31'd0, upd_pulse}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dodgypla_input_sequencer.md
Name: dodgypla_input_sequencer

Overview:
- Sequencing front-end for the combinational PLA decode core. Runs on a fast oversampling clock.
- Synchronises the 16 asynchronous PLA input pins and waits for a stable input vector before applying it to the core.
- Waits a fixed decode time, then latches the core's 8 outputs into registered, glitch-free pin drivers.
- Sits between the board pins and the decode core. Also counts input glitches and flags stability timeouts.

Parameters:
- FILTER_CYCLES, 3: consecutive identical synchronised samples required before a vector is applied (min 1).
- DECODE_CYCLES, 2: clocks allowed for core propagation before outputs are captured (min 1).
- MAX_WAIT, 16: SETTLE-state cycle limit before a forced apply (must be > FILTER_CYCLES).

Ports:
- clk  in  1  oversampling clock
- rst_n  in  1  asynchronous active-low reset
- pla_pins  in  16  raw asynchronous PLA inputs; bit n = core input in
- cfg_bypass  in  1  1 = transparent registered mode with filtering disabled
- glitch_clr  in  1  synchronous clear of glitch_cnt
- core_in  out  16  vector applied to decode core inputs i0..i15
- core_out  in  8  decode core outputs f0..f7
- f_out  out  8  registered PLA outputs to pins
- upd_pulse  out  1  one-clock pulse when f_out is loaded in FSM mode
- timeout_pulse  out  1  one-clock pulse on a forced apply
- glitch_cnt  out  8  saturating count of candidate changes during SETTLE

Behaviour:
- Reset (async, rst_n=0):
  - sync flops, cand, core_in and all counters = 0.
  - f_out = 8'hFF (all selects deasserted); pulses = 0; state = IDLE.
- Synchronisation: 2-flop synchroniser on all pla_pins bits; sync_in is valid 2 edges after sampling.
- FSM states: IDLE, SETTLE, EVAL.
- IDLE:
  - If sync_in != core_in: load cand <= sync_in, stab = 0, wait = 0, go to SETTLE.
  - Otherwise hold.
- SETTLE (evaluated every cycle):
  - wait increments each cycle.
  - If sync_in != cand: cand <= sync_in, stab <= 0, glitch_cnt += 1 (saturates at 255).
  - Else if stab == FILTER_CYCLES-1:
    - If cand == core_in, return to IDLE; no apply, no pulse.
    - Otherwise core_in <= cand, go to EVAL with stab = 0.
  - Else stab += 1.
  - If wait == MAX_WAIT-1 and no stable commit this cycle: core_in <= sync_in, timeout_pulse = 1, go to EVAL.
  - Stable commit takes priority over timeout.
- EVAL:
  - Count DECODE_CYCLES clocks; on the last one, f_out <= core_out, upd_pulse = 1, go to IDLE.
  - Input changes during EVAL are ignored; they are picked up by IDLE afterwards.
- Latency (no glitches): a pin change sampled at edge N appears on core_in after edge N+2+FILTER_CYCLES and on f_out after edge N+2+FILTER_CYCLES+DECODE_CYCLES. Defaults give N+7.
- glitch_clr: zeroes glitch_cnt. If it coincides with an increment, the clear wins.
- Bypass (cfg_bypass=1):
  - Each clock: core_in <= sync_in and f_out <= core_out.
  - FSM forced to IDLE; any SETTLE or EVAL is aborted; no pulses; glitch_cnt frozen.
- Leaving bypass: FSM resumes in IDLE; core_in already equals sync_in, so no spurious update.
- Reset mid-operation: immediate return to reset values. f_out drops to 8'hFF asynchronously.
- f_out changes only on upd_pulse cycles or in bypass mode; never combinationally from pins.

Test Plan:
1. Reset release, pla_pins = 16'h0000, core model returns 8'hA5 for that vector → f_out stays 8'hFF. Change pins to 16'h2CE6 → upd_pulse at edge N+7, f_out = core_out for 16'h2CE6; timeout_pulse = 0; glitch_cnt = 0.
2. Pins toggle 16'h0001 ↔ 16'h0000 every 2 clocks for 10 clocks, then settle at 16'h0001 → glitch_cnt > 0; exactly one upd_pulse; core_in = 16'h0001.
3. Pins toggle every clock indefinitely → timeout_pulse exactly MAX_WAIT clocks after SETTLE entry (16); core_in = sync_in at that edge; upd_pulse 2 clocks later.
4. Pins go 16'h0000 → 16'h0040 for 1 clock → back to 16'h0000 → SETTLE returns to IDLE; no upd_pulse; f_out unchanged; glitch_cnt = 1.
5. cfg_bypass = 1 with pins stepping 16'h0000, 16'hFFFF → core_in follows 2 clocks after sampling and f_out follows core_out 1 clock later. Assert bypass mid-SETTLE → FSM in IDLE next cycle, no pulse.
6. Assert rst_n = 0 during EVAL → f_out = 8'hFF immediately, state IDLE. glitch_cnt at 255 plus a further glitch stays at 255; glitch_clr → 0.
